// File: rtl/mem_port_stall_ctrl_pkg.sv
// mem_port_stall_ctrl_pkg: shared FSM state encoding and default memory latency
package mem_port_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } state_e;

    localparam int DEF_MEM_LAT = 2;

endpackage

// File: rtl/mem_port_stall_ctrl_wait_counter.sv
// wait_counter: loadable down-counter that saturates at zero and flags zero
module wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // load wins over decrement; decrement never wraps below zero
    always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_stall_ctrl.sv
// mem_port_stall_ctrl: serialises fetch and data accesses onto one fixed-latency memory port
module mem_port_stall_ctrl
    import mem_port_stall_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

    state_e            state_q;
    logic              if_served_q, dm_served_q, mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
    logic              if_pend, dm_pend, busy, start, cnt_zero;

    assign if_pend = if_req & ~if_served_q;
    assign dm_pend = dm_req & ~dm_served_q;
    assign stall   = if_pend | dm_pend;
    assign busy    = (state_q != ST_IDLE);
    assign start   = ~busy & stall;

    wait_counter #(.CNT_W(CNT_W)) u_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (start),
        .load_val_i (LOAD_VAL),
        .dec_i      (busy),
        .zero_o     (cnt_zero)
    );

    // arbitration FSM: data first, then fetch; served bits clear on every pipeline advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            if_served_q <= 1'b0;
            dm_served_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (!stall) begin
                if_served_q <= 1'b0;
                dm_served_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (dm_pend) begin
                        state_q     <= ST_BUSY_DM;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                    end else if (if_pend) begin
                        state_q    <= ST_BUSY_IF;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                    end
                end
                ST_BUSY_IF: begin
                    if (cnt_zero) begin
                        if_rdata_q <= mem_rdata;
                        if (if_req) if_served_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_BUSY_DM: begin
                    if (cnt_zero) begin
                        if (!mem_we_q) dm_rdata_q <= mem_rdata;
                        if (dm_req) dm_served_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_stall_ctrl.sv
// tb_mem_port_stall_ctrl: directed stimulus checked against a transaction-level model of the port
module tb_mem_port_stall_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, stall;

    int vec = 0, errs = 0, we_n = 0;
    logic [31:0] addrs[$];

    always #5 clk = ~clk;

    mem_port_stall_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C01_0004 : (a ^ 32'hA5A5_0000);
    endfunction

    assign mem_rdata = mem_req ? mem_f(mem_addr) : 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: an access occupies the port for LAT cycles; a step ends when nothing is outstanding
    int          m_left = 0, m_who = 0;
    logic        m_if_srv = 0, m_dm_srv = 0, m_we = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;

    always @(posedge clk or negedge rst_n) begin : mdl
        logic ifs, dms;
        if (!rst_n) begin
            m_left = 0; m_who = 0; m_if_srv = 0; m_dm_srv = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_if_rd = '0; m_dm_rd = '0;
        end else begin
            ifs = m_if_srv;
            dms = m_dm_srv;
            if (!((if_req && !ifs) || (dm_req && !dms))) begin
                m_if_srv = 0;
                m_dm_srv = 0;
            end
            if (m_left == 0) begin
                if (dm_req && !dms) begin
                    m_left = LAT; m_who = 2; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
                end else if (if_req && !ifs) begin
                    m_left = LAT; m_who = 1; m_we = 0; m_addr = if_addr;
                end
            end else if (m_left == 1) begin
                if (m_who == 1) begin
                    m_if_rd = mem_f(m_addr);
                    if (if_req) m_if_srv = 1;
                end else begin
                    if (!m_we) m_dm_rd = mem_f(m_addr);
                    if (dm_req) m_dm_srv = 1;
                end
                m_left = 0; m_we = 0; m_who = 0;
            end else m_left--;
        end
    end

    // per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall", {31'b0, stall}, {31'b0, (if_req && !m_if_srv) || (dm_req && !m_dm_srv)});
            chk("mem_req", {31'b0, mem_req}, {31'b0, m_left > 0});
            chk("mem_we", {31'b0, mem_we}, {31'b0, m_left > 0 && m_we});
            if (m_left > 0) chk("mem_addr", mem_addr, m_addr);
            if (m_left > 0 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
            chk("if_rdata", if_rdata, m_if_rd);
            chk("dm_rdata", dm_rdata, m_dm_rd);
        end
    end

    task automatic meas(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_we) we_n++;
            if (mem_req && (addrs.size() == 0 || addrs[$] != mem_addr)) addrs.push_back(mem_addr);
            if (!stall) break;
            n++;
        end
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_stall", {31'b0, stall}, 32'h0);
            chk("idle_mem_req", {31'b0, mem_req}, 32'h0);
        end
        // fetch only
        edge_drive();
        if_req = 1'b1; if_addr = 32'h40;
        meas(n);
        chk("fetch_stall_cycles", n, 3);
        edge_drive();
        if_req = 1'b0;
        chk("fetch_if_rdata", if_rdata, 32'h8C01_0004);
        // both requests, data first
        addrs.delete();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h44;
        meas(n);
        chk("both_stall_cycles", n, 6);
        chk("both_addr_count", addrs.size(), 2);
        chk("both_addr0", addrs.size() > 0 ? addrs[0] : 32'hFFFF_FFFF, 32'h100);
        chk("both_addr1", addrs.size() > 1 ? addrs[1] : 32'hFFFF_FFFF, 32'h44);
        edge_drive();
        dm_req = 1'b0; if_req = 1'b0;
        chk("both_dm_rdata", dm_rdata, 32'hA5A5_0100);
        chk("both_if_rdata", if_rdata, 32'hA5A5_0044);
        // store
        we_n = 0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        meas(n);
        chk("store_stall_cycles", n, 3);
        chk("store_we_cycles", we_n, 2);
        edge_drive();
        dm_req = 1'b0; dm_we = 1'b0;
        chk("store_dm_rdata_kept", dm_rdata, 32'hA5A5_0100);
        // flush mid-fetch
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        @(negedge clk);
        edge_drive();
        if_req = 1'b0;
        @(negedge clk);
        chk("flush_stall", {31'b0, stall}, 32'h0);
        edge_drive();
        if_req = 1'b1;
        @(negedge clk);
        chk("flush_if_rdata", if_rdata, 32'hA5A5_0080);
        chk("flush_not_served", {31'b0, stall}, 32'h1);
        meas(n);
        chk("flush_refetch_cycles", n, 2);
        edge_drive();
        if_req = 1'b0;
        // reset mid data access
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_mem_req", {31'b0, mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("async_rst_stall", {31'b0, stall}, 32'h1);
        chk("async_rst_dm_rdata", dm_rdata, 32'h0);
        edge_drive();
        rst_n = 1'b1;
        meas(n);
        chk("rst_restart_cycles", n, 3);
        edge_drive();
        dm_req = 1'b0;
        chk("rst_restart_dm_rdata", dm_rdata, 32'hA5A5_0300);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
